// File: rtl/ball_pkg.sv
// ball_pkg: shared state encoding, serve-quadrant prefixes and default angle resolution
package ball_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, MOVE = 2'd2, SCORED = 2'd3} state_t;
  localparam int THETA_WIDTH_DEF = 6;
  // Indexed by entropy[4:3]; keeps serves out of the near-vertical sectors.
  localparam logic [3:0][2:0] QUAD_PFX = {3'b111, 3'b100, 3'b011, 3'b000};
endpackage

// File: rtl/ball_if.sv
// ball_if: control inputs and status outputs of the ball engine
//   master drives tick/pause/serve/entropy/paddles, slave drives x/y/speed/state/event pulses
interface ball_if #(
  parameter int X_BITS = 5,
  parameter int Y_BITS = 5
);
  logic                 tick;
  logic                 pause;
  logic                 serve;
  logic [4:0]           entropy;
  logic [2**Y_BITS-1:0] lpaddle;
  logic [2**Y_BITS-1:0] rpaddle;
  logic [X_BITS-1:0]    x;
  logic [Y_BITS-1:0]    y;
  logic [3:0]           speed;
  logic [1:0]           state;
  logic                 hit;
  logic                 score_left;
  logic                 score_right;
  modport master (output tick, pause, serve, entropy, lpaddle, rpaddle,
                  input x, y, speed, state, hit, score_left, score_right);
  modport slave (input tick, pause, serve, entropy, lpaddle, rpaddle,
                 output x, y, speed, state, hit, score_left, score_right);
endinterface

// File: rtl/ball_trig.sv
// trig: registered signed 8-bit sine/cosine of an angle, one-cycle latency
//   clk, reset_n : clock, async active-low reset
//   i_theta      : angle, 2^THETA_WIDTH steps per turn
//   o_sin, o_cos : 127-scaled sine and cosine of the previous cycle's i_theta
module trig
  import ball_pkg::*;
#(
  parameter int THETA_WIDTH = THETA_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [THETA_WIDTH-1:0] i_theta,
  output logic signed [7:0]      o_sin,
  output logic signed [7:0]      o_cos
);
  // Quarter-wave table, round(127*sin(k*pi/32)) for k = 0..16.
  localparam logic [16:0][7:0] QTAB = {8'd127, 8'd126, 8'd125, 8'd122, 8'd117, 8'd112,
                                      8'd106, 8'd98, 8'd90, 8'd81, 8'd71, 8'd60,
                                      8'd49, 8'd37, 8'd25, 8'd12, 8'd0};
  logic [5:0] w_a;
  function automatic logic signed [7:0] sin64(input logic [5:0] a);
    logic [4:0] i;
    i = a[4] ? 5'd16 - {1'b0, a[3:0]} : {1'b0, a[3:0]};
    return a[5] ? -$signed(QTAB[i]) : $signed(QTAB[i]);
  endfunction
  // Normalise any angle width to the 64-step table.
  assign w_a = 6'((16'(i_theta) << (16 - THETA_WIDTH)) >> 10);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      o_sin <= '0;
      o_cos <= '0;
    end else begin
      o_sin <= sin64(w_a);
      o_cos <= sin64(w_a + 6'd16);
    end
endmodule

// File: rtl/ball_engine.sv
// ball_engine: fixed-point ball mover with paddle/wall bounces, scoring and serve delay
//   clk, reset_n : clock, async active-low reset
//   bus (slave)  : tick/pause/serve/entropy/lpaddle/rpaddle in;
//                  x/y/speed/state and hit/score_left/score_right pulses out
module ball_engine
  import ball_pkg::*;
#(
  parameter int         X_BITS      = 5,
  parameter int         Y_BITS      = 5,
  parameter int         FRAC_BITS   = 16,
  parameter int         THETA_WIDTH = THETA_WIDTH_DEF,
  parameter logic [3:0] SPEED_INIT  = 4'd4,
  parameter logic [3:0] SPEED_MAX   = 4'd15,
  parameter int         SERVE_DELAY = 1000
) (
  input logic  clk,
  input logic  reset_n,
  ball_if.slave bus
);
  localparam int HW = X_BITS + FRAC_BITS;
  localparam int VW = Y_BITS + FRAC_BITS;
  localparam int CW = $clog2(SERVE_DELAY + 1);
  localparam logic [HW-1:0] H_CTR = {1'b1, {(HW-1){1'b0}}};
  localparam logic [VW-1:0] V_CTR = {1'b1, {(VW-1){1'b0}}};
  localparam logic [THETA_WIDTH-1:0] T_HALF = {1'b1, {(THETA_WIDTH-1){1'b0}}};
  state_t                  r_state, w_state;
  logic [HW-1:0]           r_h, w_h, w_nh;
  logic [VW-1:0]           r_v, w_v, w_nv;
  logic [THETA_WIDTH-1:0]  r_theta, w_theta, w_bounce, w_serve_theta;
  logic [3:0]              r_speed, w_speed;
  logic [CW-1:0]           r_cnt, w_cnt;
  logic                    r_hit, r_sl, r_sr, w_hit, w_sl, w_sr;
  logic signed [7:0]       w_sin, w_cos;
  logic signed [12:0]      w_dx, w_dy;
  logic [X_BITS-1:0]       w_col, w_ncol;
  logic [Y_BITS-1:0]       w_row, w_nrow;
  logic                    w_left, w_right, w_vert, w_pad;
  // Trig follows r_theta one cycle late; SETTLE absorbs that after every theta change.
  trig #(.THETA_WIDTH(THETA_WIDTH)) u_trig (
    .clk    (clk),
    .reset_n(reset_n),
    .i_theta(r_theta),
    .o_sin  (w_sin),
    .o_cos  (w_cos)
  );
  assign w_dx = w_cos * $signed({1'b0, r_speed});
  assign w_dy = w_sin * $signed({1'b0, r_speed});
  assign w_nh = r_h + HW'(w_dx);
  assign w_nv = r_v + VW'(w_dy);
  assign w_col = r_h[HW-1 -: X_BITS];
  assign w_ncol = w_nh[HW-1 -: X_BITS];
  assign w_row = r_v[VW-1 -: Y_BITS];
  assign w_nrow = w_nv[VW-1 -: Y_BITS];
  // Edges are integer-cell wraps in the direction of travel.
  assign w_left = w_cos[7] && w_col == '0 && w_ncol == '1;
  assign w_right = !w_cos[7] && w_col == '1 && w_ncol == '0;
  assign w_vert = w_sin[7] ? (w_row == '0 && w_nrow == '1) : (w_row == '1 && w_nrow == '0);
  assign w_pad = w_left ? bus.lpaddle[w_nrow] : bus.rpaddle[w_nrow];
  assign w_bounce = THETA_WIDTH'($signed(bus.entropy[2:0]));
  assign w_serve_theta = THETA_WIDTH'({QUAD_PFX[bus.entropy[4:3]], bus.entropy[2:0]});
  always_comb begin
    w_state = r_state;
    w_h = r_h;
    w_v = r_v;
    w_theta = r_theta;
    w_speed = r_speed;
    w_cnt = r_cnt;
    w_hit = 1'b0;
    w_sl = 1'b0;
    w_sr = 1'b0;
    if (!bus.pause)
      case (r_state)
        IDLE: if (bus.serve) begin
          w_theta = w_serve_theta;
          w_speed = SPEED_INIT;
          w_state = SETTLE;
        end
        SETTLE: w_state = MOVE;
        MOVE: if (bus.tick) begin
          if (w_left || w_right) begin
            if (w_pad) begin
              w_hit = 1'b1;
              w_theta = T_HALF - r_theta + w_bounce;
              w_speed = r_speed >= SPEED_MAX ? SPEED_MAX : r_speed + 4'd1;
              w_state = SETTLE;
            end else begin
              w_sl = w_right;
              w_sr = w_left;
              w_cnt = '0;
              w_state = SCORED;
            end
          end else if (w_vert) begin
            w_theta = w_bounce - r_theta;
            w_state = SETTLE;
          end else begin
            w_h = w_nh;
            w_v = w_nv;
          end
        end
        SCORED: if (bus.tick) begin
          w_cnt = r_cnt + CW'(1);
          if (r_cnt == CW'(SERVE_DELAY - 1)) begin
            w_cnt = '0;
            w_h = H_CTR;
            w_v = V_CTR;
            w_state = IDLE;
          end
        end
        default: w_state = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state <= IDLE;
      r_h <= H_CTR;
      r_v <= V_CTR;
      r_theta <= '0;
      r_speed <= SPEED_INIT;
      r_cnt <= '0;
      r_hit <= 1'b0;
      r_sl <= 1'b0;
      r_sr <= 1'b0;
    end else begin
      r_state <= w_state;
      r_h <= w_h;
      r_v <= w_v;
      r_theta <= w_theta;
      r_speed <= w_speed;
      r_cnt <= w_cnt;
      r_hit <= w_hit;
      r_sl <= w_sl;
      r_sr <= w_sr;
    end
  assign bus.x = w_col;
  assign bus.y = w_row;
  assign bus.speed = r_speed;
  assign bus.state = r_state;
  assign bus.hit = r_hit;
  assign bus.score_left = r_sl;
  assign bus.score_right = r_sr;
endmodule
